// File: rtl/oled_pkg.sv
// ============================================================================
//  Module   : oled_pkg
//  Purpose  : Shared geometry, index width and pixel/phase types for the
//             PmodOLEDrgb (SSD1331) serial-stream receiver.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package oled_pkg;

    localparam int OLED_WIDTH  = 96;
    localparam int OLED_HEIGHT = 64;
    localparam int OLED_PIXELS = 6143 + 1;

    localparam int PIX_IDX_W = 13;

    typedef logic [PIX_IDX_W-1:0] pix_idx_t;

    typedef struct packed {
        logic [4:0] red;
        logic [5:0] green;
        logic [4:0] blue;
    } rgb565_t;

    // Which half of a 16-bit pixel the next data byte fills.
    typedef enum logic [0:0] {
        HI = 1'b0,
        LO = 1'b1
    } byte_phase_t;

    function automatic rgb565_t rgb565_pack(input logic [7:0] hi, input logic [7:0] lo);
        return rgb565_t'({hi, lo});
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
//  Module   : sync_edge_det
//  Purpose  : SYNC_STAGES-deep synchroniser for one asynchronous line with
//             registered rise/fall pulses and a level aligned to the pulses.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clock_100mhz,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   last;
    logic                   synced;

    assign synced = chain[SYNC_STAGES-1];
    // level is one flop behind the synchroniser so it lines up with rise/fall.
    assign level  = last;

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            last  <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
            last  <= synced;
            rise  <= synced & ~last;
            fall  <= ~synced & last;
        end
    end

endmodule

`default_nettype wire

// File: rtl/oled_spi_rx.sv
// ============================================================================
//  Module   : oled_spi_rx
//  Purpose  : Listen-only decoder of the SSD1331 serial stream: rebuilds
//             command bytes and raster-indexed RGB565 pixels.
//             Optional: define OLED_SPI_RX_CHECKSUM_EN for the frame_sum output.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module oled_spi_rx
    import oled_pkg::*;
#(
    parameter int WIDTH       = OLED_WIDTH,
    parameter int HEIGHT      = OLED_HEIGHT,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock_100mhz,
    input  logic        reset,
    input  logic        cs,
    input  logic        sdin,
    input  logic        sclk,
    input  logic        d_cn,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        pixel_valid,
    output logic [15:0] pixel_data,
    output logic [12:0] pixel_index,
    output logic        frame_done
`ifdef OLED_SPI_RX_CHECKSUM_EN
    ,
    output logic [15:0] frame_sum
`endif
);

    localparam pix_idx_t LAST_INDEX = pix_idx_t'(WIDTH * HEIGHT - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sclk_sync (
        .clock_100mhz (clock_100mhz),
        .reset        (reset),
        .async_in     (sclk),
        .level        (sclk_level),
        .rise         (sclk_rise),
        .fall         (sclk_fall)
    );

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clock_100mhz (clock_100mhz),
        .reset        (reset),
        .async_in     (cs),
        .level        (cs_level),
        .rise         (cs_rise),
        .fall         (cs_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_level, sclk_fall, cs_fall};

    // One stage deeper than the edge detectors so sdin/d_cn match the pulse timing.
    logic [SYNC_STAGES:0] sdin_chain;
    logic [SYNC_STAGES:0] d_cn_chain;
    logic                 sdin_s;
    logic                 d_cn_s;

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            sdin_chain <= '0;
            d_cn_chain <= '0;
        end else begin
            sdin_chain <= {sdin_chain[SYNC_STAGES-1:0], sdin};
            d_cn_chain <= {d_cn_chain[SYNC_STAGES-1:0], d_cn};
        end
    end

    assign sdin_s = sdin_chain[SYNC_STAGES];
    assign d_cn_s = d_cn_chain[SYNC_STAGES];

    logic [7:0]  shift_reg;
    logic [2:0]  bit_cnt;
    logic [7:0]  hi_byte;
    byte_phase_t byte_phase;
    pix_idx_t    next_index;

    logic        edge_ok;
    logic        byte_done;
    logic        cmd_done;
    logic        pix_done;
    logic        frame_end;
    logic [7:0]  new_byte;
    rgb565_t     pix_word;

    // An edge coinciding with cs rising belongs to no byte.
    assign edge_ok   = sclk_rise & ~cs_level & ~cs_rise;
    assign byte_done = edge_ok & (bit_cnt == 3'd7);
    assign cmd_done  = byte_done & ~d_cn_s;
    assign pix_done  = byte_done & d_cn_s & (byte_phase == LO);
    assign frame_end = pix_done & (next_index == LAST_INDEX);
    assign new_byte  = {shift_reg[6:0], sdin_s};
    assign pix_word  = rgb565_pack(hi_byte, new_byte);

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            hi_byte     <= '0;
            byte_phase  <= HI;
            next_index  <= '0;
            cmd_valid   <= 1'b0;
            cmd_byte    <= '0;
            pixel_valid <= 1'b0;
            pixel_data  <= '0;
            pixel_index <= '0;
            frame_done  <= 1'b0;
        end else begin
            cmd_valid   <= 1'b0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;

            if (cs_rise) begin
                // Partial byte dropped; pixel phase and raster position survive.
                bit_cnt <= '0;
            end else if (edge_ok) begin
                shift_reg <= new_byte;
                bit_cnt   <= bit_cnt + 3'd1;
            end

            if (cmd_done) begin
                cmd_byte   <= new_byte;
                cmd_valid  <= 1'b1;
                byte_phase <= HI;
                next_index <= '0;
            end else if (byte_done && byte_phase == HI) begin
                hi_byte    <= new_byte;
                byte_phase <= LO;
            end else if (pix_done) begin
                pixel_data  <= pix_word;
                pixel_index <= next_index;
                pixel_valid <= 1'b1;
                byte_phase  <= HI;
                if (frame_end) begin
                    next_index <= '0;
                    frame_done <= 1'b1;
                end else begin
                    next_index <= next_index + pix_idx_t'(1);
                end
            end
        end
    end

`ifdef OLED_SPI_RX_CHECKSUM_EN
    logic [15:0] sum_acc;

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            sum_acc   <= '0;
            frame_sum <= '0;
        end else if (cmd_done) begin
            sum_acc <= '0;
        end else if (pix_done) begin
            if (frame_end) begin
                frame_sum <= sum_acc + pix_word;
                sum_acc   <= '0;
            end else begin
                sum_acc <= sum_acc + pix_word;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_oled_spi_rx.sv
// ============================================================================
//  Module   : tb_oled_spi_rx
//  Purpose  : Self-checking bench for oled_spi_rx on a reduced 8x4 raster.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_oled_spi_rx;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int SS   = 2;
    localparam int LAT  = SS + 2;
    localparam int SLOW = 8;

    logic        clock_100mhz = 1'b0;
    logic        reset = 1'b1;
    logic        cs    = 1'b1;
    logic        sdin  = 1'b0;
    logic        sclk  = 1'b0;
    logic        d_cn  = 1'b0;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        pixel_valid;
    logic [15:0] pixel_data;
    logic [12:0] pixel_index;
    logic        frame_done;
`ifdef OLED_SPI_RX_CHECKSUM_EN
    logic [15:0] frame_sum;
`endif

    oled_spi_rx #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .SYNC_STAGES (SS)
    ) dut (
        .clock_100mhz (clock_100mhz),
        .reset        (reset),
        .cs           (cs),
        .sdin         (sdin),
        .sclk         (sclk),
        .d_cn         (d_cn),
        .cmd_valid    (cmd_valid),
        .cmd_byte     (cmd_byte),
        .pixel_valid  (pixel_valid),
        .pixel_data   (pixel_data),
        .pixel_index  (pixel_index),
        .frame_done   (frame_done)
`ifdef OLED_SPI_RX_CHECKSUM_EN
        ,
        .frame_sum    (frame_sum)
`endif
    );

    always #5 clock_100mhz = ~clock_100mhz;

    int cyc = 0;
    always @(posedge clock_100mhz) cyc++;

    int checks = 0;
    int passed = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            passed++;
    endfunction

    typedef struct {
        bit          is_cmd;
        logic [15:0] val;
        logic [12:0] idx;
        bit          fd;
        int          at;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];

    always @(negedge clock_100mhz) begin
        if (!reset) begin
            if (cmd_valid || pixel_valid)
                chk("cmd_pix_exclusive", {31'd0, cmd_valid & pixel_valid}, 32'd0);
            if (frame_done)
                chk("frame_done_with_pixel", {31'd0, pixel_valid}, 32'd1);
            if (cmd_valid)
                obs_q.push_back('{1'b1, {8'h00, cmd_byte}, 13'd0, 1'b0, cyc});
            if (pixel_valid)
                obs_q.push_back('{1'b0, pixel_data, pixel_index, frame_done, cyc});
        end
    end

    // Reference model: byte-level protocol rules only.
    bit          m_have_hi;
    logic [7:0]  m_hi;
    int          m_next;
    logic [15:0] m_acc;
    logic [15:0] m_sum;

    function automatic void m_reset();
        m_have_hi = 0;
        m_hi      = 8'h00;
        m_next    = 0;
        m_acc     = 16'h0;
        m_sum     = 16'h0;
    endfunction

    function automatic void m_byte(input logic [7:0] b, input bit dc);
        logic [15:0] pix;
        bit          last;
        if (!dc) begin
            exp_q.push_back('{1'b1, {8'h00, b}, 13'd0, 1'b0, 0});
            m_have_hi = 0;
            m_next    = 0;
            m_acc     = 16'h0;
        end else if (!m_have_hi) begin
            m_hi      = b;
            m_have_hi = 1;
        end else begin
            pix  = {m_hi, b};
            last = (m_next == NPIX - 1);
            exp_q.push_back('{1'b0, pix, 13'(m_next), last, 0});
            m_acc = m_acc + pix;
            if (last) begin
                m_sum = m_acc;
                m_acc = 16'h0;
            end
            m_next    = (m_next + 1) % NPIX;
            m_have_hi = 0;
        end
    endfunction

    int last_rise = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clock_100mhz);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input bit dc, input int nbits, input int half);
        if (cs) begin
            cs = 1'b0;
            tick(half);
        end
        d_cn = dc;
        for (int i = 7; i > 7 - nbits; i--) begin
            sdin = b[i];
            sclk = 1'b0;
            tick(half);
            sclk = 1'b1;
            last_rise = cyc;
            tick(half);
        end
        sclk = 1'b0;
    endtask

    task automatic send_model(input logic [7:0] b, input bit dc, input int half);
        send_bits(b, dc, 8, half);
        m_byte(b, dc);
    endtask

    task automatic cs_high(input int half);
        sclk = 1'b0;
        cs   = 1'b1;
        tick(half);
    endtask

    task automatic compare_queues(input string name);
        tick(LAT + 8);
        chk($sformatf("%s_count", name), obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_kind[%0d]", name, i), {31'd0, obs_q[i].is_cmd}, {31'd0, exp_q[i].is_cmd});
            chk($sformatf("%s_value[%0d]", name, i), {16'd0, obs_q[i].val}, {16'd0, exp_q[i].val});
            if (!exp_q[i].is_cmd) begin
                chk($sformatf("%s_index[%0d]", name, i), {19'd0, obs_q[i].idx}, {19'd0, exp_q[i].idx});
                chk($sformatf("%s_frame_done[%0d]", name, i), {31'd0, obs_q[i].fd}, {31'd0, exp_q[i].fd});
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_cmd_valid"},   {31'd0, cmd_valid},   32'd0);
        chk({name, "_cmd_byte"},    {24'd0, cmd_byte},    32'd0);
        chk({name, "_pixel_valid"}, {31'd0, pixel_valid}, 32'd0);
        chk({name, "_pixel_data"},  {16'd0, pixel_data},  32'd0);
        chk({name, "_pixel_index"}, {19'd0, pixel_index}, 32'd0);
        chk({name, "_frame_done"},  {31'd0, frame_done},  32'd0);
`ifdef OLED_SPI_RX_CHECKSUM_EN
        chk({name, "_frame_sum"},   {16'd0, frame_sum},   32'd0);
`endif
    endtask

    typedef struct {
        logic [7:0]  b;
        bit          dc;
        int          n_ev;
        bit          is_cmd;
        logic [15:0] val;
        logic [12:0] idx;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{8'hAF, 1'b0, 1, 1'b1, 16'h00AF, 13'd0};
        vt[1] = '{8'h15, 1'b0, 1, 1'b1, 16'h0015, 13'd0};
        vt[2] = '{8'hF8, 1'b1, 0, 1'b0, 16'h0000, 13'd0};
        vt[3] = '{8'h00, 1'b1, 1, 1'b0, 16'hF800, 13'd0};
        vt[4] = '{8'h07, 1'b1, 0, 1'b0, 16'h0000, 13'd0};
        vt[5] = '{8'hE0, 1'b1, 1, 1'b0, 16'h07E0, 13'd1};
        vt[6] = '{8'hAB, 1'b1, 0, 1'b0, 16'h0000, 13'd0};
        vt[7] = '{8'h75, 1'b0, 1, 1'b1, 16'h0075, 13'd0};
        vt[8] = '{8'h00, 1'b1, 0, 1'b0, 16'h0000, 13'd0};
        vt[9] = '{8'hFF, 1'b1, 1, 1'b0, 16'h00FF, 13'd0};

        m_reset();
        tick(3);
        check_outputs_zero("reset_state");
        reset = 1'b0;
        tick(4);

        // Directed table at 6.25 MHz.
        for (int v = 0; v < 10; v++) begin
            send_bits(vt[v].b, vt[v].dc, 8, SLOW);
            tick(LAT + 6);
            chk($sformatf("vec%0d_events", v), obs_q.size(), vt[v].n_ev);
            if (obs_q.size() == 1 && vt[v].n_ev == 1) begin
                chk($sformatf("vec%0d_kind", v), {31'd0, obs_q[0].is_cmd}, {31'd0, vt[v].is_cmd});
                chk($sformatf("vec%0d_value", v), {16'd0, obs_q[0].val}, {16'd0, vt[v].val});
                if (!vt[v].is_cmd)
                    chk($sformatf("vec%0d_index", v), {19'd0, obs_q[0].idx}, {19'd0, vt[v].idx});
                if (v == 0)
                    chk("latency", obs_q[0].at - last_rise, LAT);
            end
            obs_q.delete();
        end
        chk("cmd_byte_held", {24'd0, cmd_byte}, 32'h75);
        chk("pixel_data_held", {16'd0, pixel_data}, 32'h00FF);

        // Model now tracks: phase HI, next index 1.
        m_reset();
        m_next = 1;

        // Abort after 5 bits of a data byte, then a full pixel.
        send_bits(8'hFF, 1'b1, 5, SLOW);
        cs_high(SLOW);
        send_model(8'h12, 1'b1, SLOW);
        send_model(8'h34, 1'b1, SLOW);
        compare_queues("cs_abort");
        chk("cs_abort_pixel", {16'd0, pixel_data}, 32'h1234);

        // 7 bits of a command, then the 8th sclk rise lands together with cs rising.
        send_bits(8'h55, 1'b0, 7, SLOW);
        tick(SLOW);
        sclk = 1'b1;
        cs   = 1'b1;
        tick(SLOW);
        sclk = 1'b0;
        tick(SLOW);
        compare_queues("edge_with_cs_rise");
        chk("edge_with_cs_rise_cmd_held", {24'd0, cmd_byte}, 32'h75);

        // Full frame plus one pixel of 0x001F.
        send_model(8'h5C, 1'b0, 3);
        for (int p = 0; p <= NPIX; p++) begin
            send_model(8'h00, 1'b1, 3);
            send_model(8'h1F, 1'b1, 3);
        end
        compare_queues("frame");
        chk("frame_next_index", {19'd0, pixel_index}, 32'd0);
`ifdef OLED_SPI_RX_CHECKSUM_EN
        chk("frame_sum_model", {16'd0, frame_sum}, {16'd0, m_sum});
        chk("frame_sum_const", {16'd0, frame_sum}, (32'h1F * NPIX) & 32'hFFFF);
`endif

        // Randomised traffic with cs toggles and aborted bytes.
        for (int n = 0; n < 150; n++) begin
            int r;
            int half;
            logic [7:0] b;
            r    = $urandom_range(0, 99);
            half = $urandom_range(3, 8);
            b    = 8'($urandom);
            if (r < 12) begin
                send_model(b, 1'b0, half);
            end else if (r < 22) begin
                send_bits(b, 1'($urandom), $urandom_range(1, 7), half);
                cs_high(half);
            end else begin
                send_model(b, 1'b1, half);
            end
            if ($urandom_range(0, 4) == 0)
                cs_high(half);
        end
        compare_queues("random");

        // Reset after 10 pixels and 3 bits.
        send_model(8'hA0, 1'b0, 3);
        for (int p = 0; p < 20; p++)
            send_model(8'($urandom), 1'b1, 3);
        send_bits(8'hC3, 1'b1, 3, 3);
        compare_queues("pre_reset");
        reset = 1'b1;
        tick(2);
        check_outputs_zero("mid_reset");
        reset = 1'b0;
        tick(2);
        check_outputs_zero("after_reset");
        m_reset();
        cs_high(SLOW);
        send_model(8'hBE, 1'b1, SLOW);
        send_model(8'hEF, 1'b1, SLOW);
        compare_queues("post_reset");
        chk("post_reset_index", {19'd0, pixel_index}, 32'd0);
        chk("post_reset_pixel", {16'd0, pixel_data}, 32'hBEEF);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
